// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode values, FSM state encoding and flag bit positions.
// OP_MUL is only a legal opcode when the design is built with ALU_MUL_EN defined.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SHL   = 4'b0001;
  localparam logic [3:0] OP_SHR   = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_PASSA = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_SUB   = 4'b1000;
  localparam logic [3:0] OP_MUL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_CMP   = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  localparam int FLAG_Z    = 0;
  localparam int FLAG_C    = 1;
  localparam int FLAG_V    = 2;
  localparam int FLAG_ERR  = 3;
  localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per enabled cycle, BIT_LENGTH cycles.
// done is high during the final step; product then shows the finished sum to be captured on that edge.
module alu_mul_iter #(
  parameter int BIT_LENGTH = 8,
  parameter int RES_LENGTH = 2 * BIT_LENGTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic [BIT_LENGTH-1:0] a,
  input  logic [BIT_LENGTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [RES_LENGTH-1:0] product
);

  localparam int PW = 2 * BIT_LENGTH;
  localparam int CW = $clog2(BIT_LENGTH + 1);

  logic [PW-1:0]         acc_q;
  logic [PW-1:0]         mcand_q;
  logic [PW-1:0]         acc_next;
  logic [BIT_LENGTH-1:0] mplier_q;
  logic [CW-1:0]         cnt_q;
  logic                  busy_q;

  assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == CW'(BIT_LENGTH - 1));
  assign product  = RES_LENGTH'(acc_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (en) begin
      if (start) begin
        acc_q    <= '0;
        mcand_q  <= PW'(a);
        mplier_q <= b;
        cnt_q    <= '0;
        busy_q   <= 1'b1;
      end else if (busy_q) begin
        acc_q    <= acc_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        if (done) begin
          busy_q <= 1'b0;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked ALU between the SPI instruction decoder and the SPI response shifter.
// Build with ALU_MUL_EN defined to include the iterative multiplier (opcode 1001); otherwise it is illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int BIT_LENGTH    = 8,
  parameter int OPCODE_LENGTH = 4,
  parameter int RES_LENGTH    = 2 * BIT_LENGTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     exec_en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BIT_LENGTH-1:0]    a,
  input  logic [BIT_LENGTH-1:0]    b,
  input  logic [OPCODE_LENGTH-1:0] opcode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RES_LENGTH-1:0]    out,
  output logic                     flag_z,
  output logic                     flag_c,
  output logic                     flag_v,
  output logic                     flag_err,
  output alu_state_e               state_dbg
);

  localparam int BL = BIT_LENGTH;
  localparam int RL = RES_LENGTH;
  localparam int XW = RL - BL;
  localparam int SW = (BL > 32) ? BL : 32;

  alu_state_e            state_q, state_d;
  logic [RL-1:0]         out_q;
  logic [NUM_FLAGS-1:0]  flags_q;

  logic [SW-1:0]         shamt;
  logic [BL:0]           sum;
  logic [BL:0]           diff;
  logic [BL-1:0]         shr_v;
  logic [BL-1:0]         sra_v;
  logic [RL-1:0]         alu_res;
  logic [NUM_FLAGS-1:0]  alu_flags;
  logic [NUM_FLAGS-1:0]  mul_flags;

  logic                  is_mul;
  logic                  mul_busy;
  logic                  mul_done;
  logic [RL-1:0]         mul_product;

  logic                  ready_c;
  logic                  accept;
  logic                  load_res;
  logic                  load_mul;

  // Single-cycle datapath: every opcode except MUL resolves combinationally from the live inputs.
  assign shamt = SW'(b);
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shr_v = a >> b;
  assign sra_v = $signed(a) >>> b;

  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    case (opcode)
      OPCODE_LENGTH'(OP_ADD): begin
        alu_res           = RL'(sum);
        alu_flags[FLAG_C] = sum[BL];
        alu_flags[FLAG_V] = (a[BL-1] == b[BL-1]) && (sum[BL-1] != a[BL-1]);
      end
      OPCODE_LENGTH'(OP_SUB), OPCODE_LENGTH'(OP_CMP): begin
        alu_res           = (opcode == OPCODE_LENGTH'(OP_CMP)) ? '0
                                                               : {{XW{diff[BL-1]}}, diff[BL-1:0]};
        alu_flags[FLAG_C] = diff[BL];
        alu_flags[FLAG_V] = (a[BL-1] != b[BL-1]) && (diff[BL-1] != a[BL-1]);
      end
      OPCODE_LENGTH'(OP_SHL):   alu_res = (shamt >= SW'(RL)) ? '0 : (RL'(a) << b);
      OPCODE_LENGTH'(OP_SHR):   alu_res = (shamt >= SW'(BL)) ? '0 : RL'(shr_v);
      OPCODE_LENGTH'(OP_SRA):   alu_res = (shamt >= SW'(BL)) ? {RL{a[BL-1]}}
                                                             : {{XW{sra_v[BL-1]}}, sra_v};
      OPCODE_LENGTH'(OP_AND):   alu_res = RL'(a & b);
      OPCODE_LENGTH'(OP_OR):    alu_res = RL'(a | b);
      OPCODE_LENGTH'(OP_XOR):   alu_res = RL'(a ^ b);
      OPCODE_LENGTH'(OP_PASSA): alu_res = RL'(a);
      OPCODE_LENGTH'(OP_PASSB): alu_res = RL'(b);
`ifdef ALU_MUL_EN
      OPCODE_LENGTH'(OP_MUL):   alu_res = '0;
`endif
      default:                  alu_flags[FLAG_ERR] = 1'b1;
    endcase
    if (!alu_flags[FLAG_ERR]) begin
      alu_flags[FLAG_Z] = (opcode == OPCODE_LENGTH'(OP_CMP)) ? (a == b) : (alu_res == '0);
    end
  end

`ifdef ALU_MUL_EN
  assign is_mul = (opcode == OPCODE_LENGTH'(OP_MUL));

  alu_mul_iter #(
    .BIT_LENGTH (BL),
    .RES_LENGTH (RL)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .en      (exec_en),
    .start   (accept & is_mul),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign is_mul      = 1'b0;
  assign mul_busy    = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_Z] = (mul_product == '0);
  end

  // Handshakes: an op is taken on a rising edge where in_valid && in_ready; a result is consumed on a
  // rising edge where out_valid && out_ready && exec_en. Nothing transfers while exec_en is low.
  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    accept  = 1'b0;
    load_mul = 1'b0;
    if (exec_en) begin
      case (state_q)
        ST_IDLE: begin
          ready_c = 1'b1;
          if (in_valid) begin
            accept  = 1'b1;
            state_d = is_mul ? ST_BUSY : ST_DONE;
          end
        end
        ST_BUSY: begin
          if (mul_done) begin
            load_mul = 1'b1;
            state_d  = ST_DONE;
          end else if (!mul_busy) begin
            state_d = ST_IDLE;
          end
        end
        ST_DONE: begin
          ready_c = out_ready;
          if (out_ready) begin
            if (in_valid) begin
              accept  = 1'b1;
              state_d = is_mul ? ST_BUSY : ST_DONE;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign load_res = accept & ~is_mul;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      flags_q <= '0;
    end else if (load_res) begin
      out_q   <= alu_res;
      flags_q <= alu_flags;
    end else if (load_mul) begin
      out_q   <= mul_product;
      flags_q <= mul_flags;
    end
  end

  assign in_ready  = ready_c & ~rst;
  assign out_valid = (state_q == ST_DONE);
  assign out       = out_q;
  assign flag_z    = flags_q[FLAG_Z];
  assign flag_c    = flags_q[FLAG_C];
  assign flag_v    = flags_q[FLAG_V];
  assign flag_err  = flags_q[FLAG_ERR];
  assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases plus randomized ops against a behavioural arithmetic model.
// Expectations follow ALU_MUL_EN, so the same bench serves both builds.
`timescale 1ns/1ps
module tb_alu_seq;
  import alu_pkg::*;

  localparam int BL = 8;
  localparam int OL = 4;
  localparam int RL = 16;
  localparam int W  = RL + 4;
`ifdef ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          exec_en;
  logic          in_valid;
  logic          in_ready;
  logic [BL-1:0] a;
  logic [BL-1:0] b;
  logic [OL-1:0] opcode;
  logic          out_valid;
  logic          out_ready;
  logic [RL-1:0] out;
  logic          flag_z, flag_c, flag_v, flag_err;
  alu_state_e    state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  alu_seq #(
    .BIT_LENGTH    (BL),
    .OPCODE_LENGTH (OL),
    .RES_LENGTH    (RL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .exec_en   (exec_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_err  (flag_err),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] observed();
    return {out, flag_err, flag_v, flag_c, flag_z};
  endfunction

  // reference model: {result, err, v, c, z} from plain integer arithmetic
  function automatic logic [W-1:0] model(input logic [BL-1:0] ia, input logic [BL-1:0] ib,
                                         input logic [3:0] iop);
    longint full = longint'(1) << BL;
    longint half = full / 2;
    longint ua   = longint'(ia);
    longint ub   = longint'(ib);
    longint sa   = (ua >= half) ? ua - full : ua;
    longint sb   = (ub >= half) ? ub - full : ub;
    longint r    = 0;
    longint d    = 0;
    bit z = 0, c = 0, v = 0, err = 0;
    case (iop)
      4'h0: begin
        r = ua + ub;
        c = (r >= full);
        d = sa + sb;
        v = (d >= half) || (d < -half);
      end
      4'h8, 4'hB: begin
        d = sa - sb;
        v = (d >= half) || (d < -half);
        c = (ua < ub);
        r = (((ua - ub) % full) + full) % full;
        if (r >= half) r = r - full;
      end
      4'h1: if (ub < RL) r = ua << ub;
      4'h2: if (ub < BL) r = ua >> ub;
      4'hA: begin
        if (ub >= BL) r = (sa < 0) ? -1 : 0;
        else          r = sa >>> ub;
      end
      4'h3: r = ua & ub;
      4'h4: r = ua | ub;
      4'h5: r = ua ^ ub;
      4'h6: r = ua;
      4'h7: r = ub;
      4'h9: begin
        if (MUL_ON) r = ua * ub;
        else        err = 1;
      end
      default: err = 1;
    endcase
    if (iop == 4'hB) begin
      z = (ua == ub);
      r = 0;
    end else if (!err) begin
      z = (RL'(r) == '0);
    end
    return {RL'(r), err, v, c, z};
  endfunction

  function automatic int lat_of(input logic [3:0] iop);
    return (MUL_ON && iop == 4'h9) ? BL : 0;
  endfunction

  // driver: one op from IDLE, wait for the result, optionally stall, then consume it
  task automatic do_op(input logic [BL-1:0] ia, input logic [BL-1:0] ib, input logic [3:0] iop,
                       input logic [W-1:0] exp, input int exp_lat, input string name,
                       input int stall);
    int lat;
    a = ia; b = ib; opcode = iop; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_in_ready: got %b expected 1", name, in_ready);
    end
    tick();
    in_valid = 1'b0;
    a = BL'($urandom); b = BL'($urandom); opcode = OL'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    n_tests++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles expected %0d", name, lat, exp_lat);
    end
    n_tests++;
    if (observed() !== exp) begin
      n_fail++;
      $display("FAIL %s_result: got %h expected %h (op %h a %h b %h)", name, observed(), exp,
               iop, ia, ib);
    end
    repeat (stall) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: out_valid got %b expected 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; exec_en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    a = '1; b = '1; opcode = '0;
    repeat (2) tick();
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    n_tests++;
    if (out_valid !== 1'b0 || observed() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid %b data %h expected 0/0", out_valid, observed());
    end
    n_tests++;
    if (state_dbg !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready %b valid %b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    do_op(8'hFF, 8'h01, 4'h0, {16'h0100, 4'b0010}, 0, "add_carry", 0);
    do_op(8'h7F, 8'h01, 4'h0, {16'h0080, 4'b0100}, 0, "add_ovf", 1);
    do_op(8'h80, 8'h01, 4'h8, {16'h007F, 4'b0100}, 0, "sub_ovf", 0);
    do_op(8'h05, 8'h05, 4'hB, {16'h0000, 4'b0001}, 0, "cmp_eq", 0);
    do_op(8'h80, 8'h08, 4'h2, {16'h0000, 4'b0001}, 0, "shr_big", 0);
    do_op(8'h80, 8'h09, 4'hA, {16'hFFFF, 4'b0000}, 0, "sra_big", 0);
    do_op(8'hFF, 8'h0F, 4'h1, {16'h8000, 4'b0000}, 0, "shl_edge", 0);
    do_op(8'h12, 8'h34, 4'hF, {16'h0000, 4'b1000}, 0, "illegal", 0);
`ifdef ALU_MUL_EN
    do_op(8'hFF, 8'hFF, 4'h9, {16'hFE01, 4'b0000}, BL, "mul_max", 0);
`else
    do_op(8'hFF, 8'hFF, 4'h9, {16'h0000, 4'b1000}, 0, "mul_illegal", 0);
`endif
  endtask

  task automatic test_reset_mid_op();
    a = 8'h03; b = 8'h04; opcode = 4'h0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || observed() !== '0 || state_dbg !== ST_IDLE) begin
      n_fail++;
      $display("FAIL rst_done: got valid %b data %h state %0d expected 0/0/IDLE", out_valid,
               observed(), state_dbg);
    end
    #2 rst = 1'b0;
    tick();
`ifdef ALU_MUL_EN
    a = 8'hFF; b = 8'hFF; opcode = 4'h9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || observed() !== '0 || state_dbg !== ST_IDLE || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy: got valid %b data %h state %0d ready %b expected 0/0/IDLE/0",
               out_valid, observed(), state_dbg, in_ready);
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_busy_ready: got %b expected 1", in_ready);
    end
    tick();
    do_op(8'hA5, 8'h3C, 4'h9, model(8'hA5, 8'h3C, 4'h9), BL, "mul_after_rst", 0);
`endif
  endtask

  task automatic test_back_to_back();
    logic [BL-1:0] xa = BL'($urandom);
    logic [BL-1:0] xb = BL'($urandom);
    logic [W-1:0]  exp;
    out_ready = 1'b1; in_valid = 1'b1;
    a = xa; b = xb; opcode = 4'h5;
    tick();
    exp = {RL'(xa ^ xb), 3'b000, (xa == xb)};
    a = 8'h01; b = 8'd20; opcode = 4'h1;
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || observed() !== exp || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_xor: got valid %b ready %b data %h expected 1/1/%h", out_valid, in_ready,
               observed(), exp);
    end
    tick();
    a = 8'h80; b = 8'd3; opcode = 4'hA;
    n_tests++;
    if (out_valid !== 1'b1 || observed() !== {16'h0000, 4'b0001}) begin
      n_fail++;
      $display("FAIL b2b_shl: got valid %b data %h expected 1/%h", out_valid, observed(),
               {16'h0000, 4'b0001});
    end
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || observed() !== {16'hFFF0, 4'b0000}) begin
      n_fail++;
      $display("FAIL b2b_sra: got valid %b data %h expected 1/%h", out_valid, observed(),
               {16'hFFF0, 4'b0000});
    end
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_stall();
    logic [BL-1:0] xa = BL'($urandom);
    logic [BL-1:0] xb = BL'($urandom);
    logic [W-1:0]  exp = model(xa, xb, 4'h3);
    a = xa; b = xb; opcode = 4'h3; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      a = BL'($urandom); b = BL'($urandom); opcode = OL'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || observed() !== exp) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got valid %b ready %b data %h expected 1/0/%h", i,
                 out_valid, in_ready, observed(), exp);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_exec_en();
    logic [BL-1:0] xa = BL'($urandom);
    logic [BL-1:0] xb = BL'($urandom);
    logic [W-1:0]  exp = model(xa, xb, 4'h0);
    int lat;
    exec_en = 1'b0; in_valid = 1'b1; a = xa; b = xb; opcode = 4'h0; out_ready = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL en_idle_ready: got %b expected 0", in_ready);
    end
    repeat (3) tick();
    n_tests++;
    if (out_valid !== 1'b0 || state_dbg !== ST_IDLE) begin
      n_fail++;
      $display("FAIL en_idle_hold: got valid %b state %0d expected 0/IDLE", out_valid, state_dbg);
    end
    exec_en = 1'b1;
    tick();
    exec_en = 1'b0; out_ready = 1'b1;
    a = BL'($urandom); b = BL'($urandom); opcode = 4'h5;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || observed() !== exp) begin
        n_fail++;
        $display("FAIL en_done_hold_%0d: got valid %b ready %b data %h expected 1/0/%h", i,
                 out_valid, in_ready, observed(), exp);
      end
      tick();
    end
    exec_en = 1'b1; in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL en_done_drain: out_valid got %b expected 0", out_valid);
    end
`ifdef ALU_MUL_EN
    xa = BL'($urandom); xb = BL'($urandom);
    exp = model(xa, xb, 4'h9);
    a = xa; b = xb; opcode = 4'h9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    repeat (2) begin tick(); lat++; end
    exec_en = 1'b0;
    repeat (3) begin tick(); lat++; end
    exec_en = 1'b1;
    while (out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    n_tests++;
    if (lat != BL + 3 || observed() !== exp) begin
      n_fail++;
      $display("FAIL en_mul_stretch: got %0d cycles data %h expected %0d cycles data %h", lat,
               observed(), BL + 3, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`endif
  endtask

  task automatic test_random_ops();
    for (int i = 0; i < 30; i++) begin
      logic [BL-1:0] xa = BL'($urandom);
      logic [BL-1:0] xb = BL'($urandom);
      logic [3:0]    op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) xb = BL'($urandom_range(0, RL + 2));
      do_op(xa, xb, op, model(xa, xb, op), lat_of(op), "rand", $urandom_range(0, 2));
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [BL-1:0] xa = BL'($urandom);
      logic [BL-1:0] xb = BL'($urandom_range(0, 20));
      logic [3:0]    op = 4'($urandom_range(0, 15));
      if (MUL_ON && op == 4'h9) op = 4'hC;
      a = xa; b = xb; opcode = op; in_valid = 1'b1;
      exp_q.push_back(model(xa, xb, op));
      tick();
      exp = exp_q.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || observed() !== exp) begin
        n_fail++;
        $display("FAIL stream_%0d: got valid %b data %h expected 1/%h (op %h a %h b %h)", i,
                 out_valid, observed(), exp, op, xa, xb);
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_drain: got valid %b pending %0d expected 0/0", out_valid, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_op();
    test_back_to_back();
    test_stall();
    test_exec_en();
    test_random_ops();
    test_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
